// File: rtl/device_uart.sv
// device_uart: polled 8N1 serial port on the cluster device bus.
// STATUS / TX_DATA / RX_DATA registers, TX and RX FIFOs, one-cycle registered read data.
module device_uart #(
    parameter int         CLOCKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH     = 8,
    parameter logic [9:0] BASE_ADDR      = 10'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  device_core_id,
    input  logic        device_write_en,
    input  logic        device_read_en,
    input  logic [9:0]  device_addr,
    input  logic [15:0] device_data_out,
    output logic [15:0] device_data_in,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {REG_STATUS, REG_TX_DATA, REG_RX_DATA, REG_RSVD} reg_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

    // ---------------- bus decode ----------------
    logic sel, wr_status, wr_tx, rd_rx;
    reg_e offset;

    assign sel       = (device_addr[9:2] == BASE_ADDR[9:2]);
    assign offset    = reg_e'(device_addr[1:0]);
    assign wr_status = sel && device_write_en && (offset == REG_STATUS);
    assign wr_tx     = sel && device_write_en && (offset == REG_TX_DATA);
    assign rd_rx     = sel && device_read_en  && (offset == REG_RX_DATA);

    logic unused_data_bits;
    assign unused_data_bits = ^device_data_out[15:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [FIFO_DEPTH];
    logic [PTR_W:0] tx_wr_ptr, tx_rd_ptr;
    logic           tx_full, tx_empty, tx_push, tx_pop;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[PTR_W] != tx_rd_ptr[PTR_W]) &&
                      (tx_wr_ptr[PTR_W-1:0] == tx_rd_ptr[PTR_W-1:0]);
    assign tx_push  = wr_tx && !tx_full;

    // NOTE: FIFO storage has no reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr[PTR_W-1:0]] <= device_data_out[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // ---------------- TX shifter ----------------
    tx_state_e        tx_state, tx_state_nx;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        tx_state_nx = tx_state;
        tx_pop      = 1'b0;
        uart_tx     = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop      = 1'b1;
                    tx_state_nx = TX_START;
                end
            end
            TX_START: begin
                uart_tx = 1'b0;
                if (tx_bit_end) tx_state_nx = TX_DATA;
            end
            TX_DATA: begin
                uart_tx = tx_shift[0];
                if (tx_bit_end && tx_bit == 3'd7) tx_state_nx = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!tx_empty) begin
                        tx_pop      = 1'b1;
                        tx_state_nx = TX_START;
                    end else begin
                        tx_state_nx = TX_IDLE;
                    end
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd_ptr[PTR_W-1:0]];
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- RX synchronizer and receiver ----------------
    logic [1:0] rx_sync;
    logic       rx_s, rx_prev;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    rx_state_e        rx_state, rx_state_nx;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_bit_end, rx_push, rx_frame_err;

    assign rx_bit_end = (rx_cnt == BIT_LAST);

    always_comb begin
        rx_state_nx  = rx_state;
        rx_push      = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_state_nx = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_state_nx = RX_STOP;
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (rx_s) begin
                        rx_push     = 1'b1;
                        rx_state_nx = RX_IDLE;
                    end else begin
                        rx_frame_err = 1'b1;
                        rx_state_nx  = RX_WAIT;
                    end
                end
            end
            RX_WAIT:  if (rx_s) rx_state_nx = RX_IDLE;
            default:  rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_nx;
    end

    // After the half-bit start check, bit_end lands on the middle of every later bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == RX_IDLE || rx_state == RX_WAIT) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else if (rx_state == RX_START) begin
            rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + 1'b1;
        end else if (rx_bit_end) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [FIFO_DEPTH];
    logic [PTR_W:0] rx_wr_ptr, rx_rd_ptr;
    logic           rx_full, rx_empty, rx_pop, rx_accept, rx_over;

    assign rx_empty  = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full   = (rx_wr_ptr[PTR_W] != rx_rd_ptr[PTR_W]) &&
                       (rx_wr_ptr[PTR_W-1:0] == rx_rd_ptr[PTR_W-1:0]);
    assign rx_pop    = rd_rx && !rx_empty;
    assign rx_accept = rx_push && (!rx_full || rx_pop);
    assign rx_over   = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rx_accept) rx_mem[rx_wr_ptr[PTR_W-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_accept) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // ---------------- sticky status and read data ----------------
    logic       tx_overflow, rx_overrun, framing_err;
    logic [3:0] last_core;
    logic [15:0] status, rd_value;

    // A same-cycle set wins over a software clear so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
            framing_err <= 1'b0;
            last_core   <= '0;
        end else begin
            if (wr_tx && tx_full)                         tx_overflow <= 1'b1;
            else if (wr_status && device_data_out[3])     tx_overflow <= 1'b0;
            if (rx_over)                                  rx_overrun  <= 1'b1;
            else if (wr_status && device_data_out[4])     rx_overrun  <= 1'b0;
            if (rx_frame_err)                             framing_err <= 1'b1;
            else if (wr_status && device_data_out[5])     framing_err <= 1'b0;
            if (tx_push)                                  last_core   <= device_core_id;
        end
    end

    assign status = {4'h0, last_core, 2'b00, framing_err, rx_overrun, tx_overflow,
                     (!tx_empty || tx_state != TX_IDLE), !rx_empty, tx_full};

    always_comb begin
        rd_value = '0;
        if (sel) begin
            case (offset)
                REG_STATUS:  rd_value = status;
                REG_RX_DATA: if (!rx_empty) rd_value = {8'h00, rx_mem[rx_rd_ptr[PTR_W-1:0]]};
                default:     rd_value = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              device_data_in <= '0;
        else if (device_read_en) device_data_in <= rd_value;
    end
endmodule

// File: tb/tb_device_uart.sv
// Directed bench for device_uart with CLOCKS_PER_BIT=4, FIFO_DEPTH=8.
// Each task drives one scenario and compares against hand-computed values.
module tb_device_uart;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  device_core_id;
    logic        device_write_en;
    logic        device_read_en;
    logic [9:0]  device_addr;
    logic [15:0] device_data_out;
    logic [15:0] device_data_in;
    logic        uart_tx;
    logic        uart_rx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    device_uart #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(8), .BASE_ADDR(10'h000)) dut (
        .clk             (clk),
        .reset           (reset),
        .device_core_id  (device_core_id),
        .device_write_en (device_write_en),
        .device_read_en  (device_read_en),
        .device_addr     (device_addr),
        .device_data_out (device_data_out),
        .device_data_in  (device_data_in),
        .uart_tx         (uart_tx),
        .uart_rx         (uart_rx)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Bus tasks start on a negedge and return on the next one, so back-to-back calls are contiguous.
    task automatic bus_write(input logic [9:0] addr, input logic [15:0] data, input logic [3:0] core);
        device_addr     = addr;
        device_data_out = data;
        device_core_id  = core;
        device_write_en = 1'b1;
        @(negedge clk);
        device_write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [9:0] addr, output logic [15:0] data);
        device_addr    = addr;
        device_read_en = 1'b1;
        @(negedge clk);
        device_read_en = 1'b0;
        data = device_data_in;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input logic pop_at_push,
                           output logic [15:0] popped);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        popped  = 16'h0000;
        if (pop_at_push) bus_read(10'h002, popped);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b0;
        device_core_id = '0; device_write_en = 0; device_read_en = 0;
        device_addr = '0; device_data_out = '0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", uart_tx); end
        checks++;
        if (device_data_in !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", device_data_in); end
        reset = 1'b1;
        @(negedge clk);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_status got %h exp 0000", d); end
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_idle_tx got %b exp 1", uart_tx); end
    endtask

    task automatic test_tx_frame();
        logic [9:0]  exp_bits;
        logic [15:0] d;
        exp_bits = 10'b1010101010;
        bus_write(10'h001, 16'h1255, 4'd3);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_before_start got %b exp 1", uart_tx); end
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin device_addr = 10'h000; device_read_en = 1'b1; end
            @(negedge clk);
            device_read_en = 1'b0;
            checks++;
            if (uart_tx !== exp_bits[i/4]) begin
                errors++; $display("FAIL tx_bit sample %0d got %b exp %b", i, uart_tx, exp_bits[i/4]);
            end
            if (i == 20) begin
                checks++;
                if (device_data_in !== 16'h0304) begin errors++; $display("FAIL tx_mid_status got %h exp 0304", device_data_in); end
            end
        end
        @(negedge clk);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0300) begin errors++; $display("FAIL tx_done_status got %h exp 0300", d); end
    endtask

    task automatic test_rx_frame();
        logic [15:0] d;
        send_rx(8'hA5, 1'b1, 1'b0, d);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0302) begin errors++; $display("FAIL rx_status got %h exp 0302", d); end
        bus_read(10'h002, d);
        checks++;
        if (d !== 16'h00A5) begin errors++; $display("FAIL rx_data got %h exp 00a5", d); end
        bus_read(10'h002, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL rx_empty_read got %h exp 0000", d); end
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0300) begin errors++; $display("FAIL rx_status_after got %h exp 0300", d); end
    endtask

    task automatic test_misc_regs();
        logic [15:0] d;
        bus_write(10'h003, 16'h00FF, 4'd9);
        bus_write(10'h005, 16'h0077, 4'd9);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0300) begin errors++; $display("FAIL ignored_writes_status got %h exp 0300", d); end
        repeat (3) @(negedge clk);
        checks++;
        if (device_data_in !== 16'h0300) begin errors++; $display("FAIL rdata_hold got %h exp 0300", device_data_in); end
        bus_read(10'h004, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL out_of_window_read got %h exp 0000", d); end
        bus_read(10'h000, d);
        bus_read(10'h001, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL tx_data_read got %h exp 0000", d); end
        bus_read(10'h000, d);
        bus_read(10'h003, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reserved_read got %h exp 0000", d); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [7:0]  byte_v;
        logic        exp;
        int          bit_n, f, p;
        for (int k = 0; k < 10; k++) bus_write(10'h001, 16'(k), (k == 9) ? 4'd7 : 4'd5);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h050D) begin errors++; $display("FAIL b2b_full_status got %h exp 050d", d); end
        for (int s = 10; s < 364; s++) begin
            @(negedge clk);
            bit_n  = s / 4;
            f      = bit_n / 10;
            p      = bit_n % 10;
            byte_v = 8'(f);
            if (s >= 360)   exp = 1'b1;
            else if (p == 0) exp = 1'b0;
            else if (p == 9) exp = 1'b1;
            else            exp = byte_v[p-1];
            checks++;
            if (uart_tx !== exp) begin
                errors++; $display("FAIL b2b_stream sample %0d got %b exp %b", s, uart_tx, exp);
            end
        end
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0508) begin errors++; $display("FAIL b2b_drained_status got %h exp 0508", d); end
        bus_write(10'h000, 16'h0008, 4'd0);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0500) begin errors++; $display("FAIL b2b_clear_overflow got %h exp 0500", d); end
    endtask

    task automatic test_rx_full_push_pop();
        logic [15:0] d;
        for (int i = 0; i < 8; i++) send_rx(8'h20 + 8'(i), 1'b1, 1'b0, d);
        send_rx(8'h28, 1'b1, 1'b1, d);
        checks++;
        if (d !== 16'h0020) begin errors++; $display("FAIL full_pop_data got %h exp 0020", d); end
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0502) begin errors++; $display("FAIL full_pushpop_status got %h exp 0502", d); end
        for (int i = 0; i < 8; i++) begin
            bus_read(10'h002, d);
            checks++;
            if (d !== 16'h0021 + 16'(i)) begin
                errors++; $display("FAIL full_drain %0d got %h exp %h", i, d, 16'h0021 + 16'(i));
            end
        end
        bus_read(10'h002, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL full_drain_empty got %h exp 0000", d); end
    endtask

    task automatic test_rx_overrun();
        logic [15:0] d;
        for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i), 1'b1, 1'b0, d);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0512) begin errors++; $display("FAIL overrun_status got %h exp 0512", d); end
        for (int i = 0; i < 8; i++) begin
            bus_read(10'h002, d);
            checks++;
            if (d !== 16'h0010 + 16'(i)) begin
                errors++; $display("FAIL overrun_data %0d got %h exp %h", i, d, 16'h0010 + 16'(i));
            end
        end
        bus_read(10'h002, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL overrun_empty got %h exp 0000", d); end
        bus_write(10'h000, 16'h0010, 4'd0);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0500) begin errors++; $display("FAIL overrun_clear got %h exp 0500", d); end
    endtask

    task automatic test_framing_and_glitch();
        logic [15:0] d;
        send_rx(8'h3C, 1'b0, 1'b0, d);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0520) begin errors++; $display("FAIL framing_status got %h exp 0520", d); end
        bus_write(10'h000, 16'h0020, 4'd0);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0500) begin errors++; $display("FAIL framing_clear got %h exp 0500", d); end
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0500) begin errors++; $display("FAIL glitch_status got %h exp 0500", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        bus_read(10'h000, d);
        bus_write(10'h001, 16'h0000, 4'd2);
        repeat (10) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_tx_low got %b exp 0", uart_tx); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx got %b exp 1", uart_tx); end
        checks++;
        if (device_data_in !== 16'h0000) begin errors++; $display("FAIL async_reset_rdata got %h exp 0000", device_data_in); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_read(10'h000, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL post_reset_status got %h exp 0000", d); end
        repeat (8) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL post_reset_idle_tx got %b exp 1", uart_tx); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_rx_frame();
        test_misc_regs();
        test_back_to_back();
        test_rx_full_push_pop();
        test_rx_overrun();
        test_framing_and_glitch();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
